level_collision: RTL
====================

# level_collision

Sequential tile-collision checker that sits directly downstream of `level_rom` and is the only block driving its address. On a `start` pulse it maps a sprite bounding box (pixel coordinates) to the covered tile rows and columns, reads those rows from the level ROM one per cycle, and reports whether any covered tile is solid, plus the first solid tile found. Player-movement logic queries it before committing a move.

## Interface
- `SPR_W`, 32: sprite width in pixels.
- `SPR_H`, 32: sprite height in pixels.
- `TILE_W_LOG2`, 6: tile width is 2^6 = 64 px.
- `TILE_H`, 44: tile height in px.
- `ROWS`, 11: level rows, addressed 0..10.
- `COLS`, 10: level columns, 0..9.
- `Clk`  in  1: single clock.
- `Reset_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request pulse; sampled only when `busy`=0.
- `x_px`  in  10: box left edge, 0..639.
- `y_px`  in  10: box top edge, 0..479.
- `rom_addr`  out  4: row address to `level_rom`.
- `rom_data`  in  10: row data from `level_rom`; combinational, valid in the same cycle.
- `busy`  out  1: high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1: one-cycle pulse when results are valid.
- `hit`  out  1: at least one covered tile is solid.
- `hit_row`  out  4: row of the first solid tile; 0 if none.
- `hit_col`  out  4: column of the first solid tile; 0 if none.

## Operation
- Tile encoding: `rom_data` bit (COLS-1-c) is column c; MSB is the leftmost column; 1 = solid.
- FSM states are IDLE, DIV, SCAN and DONE.
- IDLE -> DIV on `start`:
  - Latch `x_px` and `y_px`.
  - Compute the bottom edge y+SPR_H-1 and the right edge x+SPR_W-1 in 11 bits.
  - c0 = x>>TILE_W_LOG2; c1 = min((x+SPR_W-1)>>TILE_W_LOG2, COLS-1).
  - Clear `hit`, `hit_row` and `hit_col`.
- DIV: two parallel repeated-subtraction dividers compute r0 = y/TILE_H and r1 = (y+SPR_H-1)/TILE_H.
  - Each cycle, each divider subtracts TILE_H and increments its quotient, unless its remainder is < TILE_H or its quotient = ROWS-1 (this caps at row 10).
  - Exit to SCAN once neither divider can step. DIV lasts r1+1 cycles.
- SCAN: a row counter starts at r0 and drives `rom_addr`.
  - Each cycle, test bits for columns c0..c1.
  - On the first solid tile (lowest row, then lowest column), latch `hit`=1, `hit_row` and `hit_col`, then go to DONE.
  - If there is no hit and the row = r1, go to DONE. Otherwise increment the row.
- DONE: `done`=1 for one cycle, then IDLE. `hit`, `hit_row` and `hit_col` hold until the next accepted `start`.
- `start` while `busy`=1 is ignored and not queued.
- `rom_addr` outside SCAN: holds its last value (0 after reset).

## Timing
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Reset asserted mid-operation returns to IDLE immediately; no `done` pulse is produced.
- Latency: with `start` sampled at edge 0, `done` is high during cycle (r1+1)+n+1, where n is the number of rows scanned (1..r1-r0+1).
  - Worst case: r0=0, r1=10, no hit gives 11+11+1 = 23 cycles.
- The result outputs are stable whenever `done`=1 and remain stable afterwards while IDLE.

## Structure
- Package `level_pkg`:
  - ROWS, COLS, TILE_W_LOG2 and TILE_H constants.
  - FSM state enum `lc_state_t`.
- Sub-module `tile_row_div`:
  - One repeated-subtraction divider with step, remainder, quotient and `ready`.
  - Instantiated twice (top edge, bottom edge).
- `level_rom` is instantiated beside this block, not inside it.

## Test plan
- Reset, then `start` with x=0, y=0: DIV 1 cycle, SCAN 1 cycle, then `done`. Response: `hit`=1, row 0, col 0.
- x=288, y=140: covers row 3, col 4 (row 3 data 0000111000). Response: `hit`=1, row 3, col 4; `done` 6 cycles after `start`.
- x=64, y=140: covers row 3, col 1. Response: `hit`=0, row 0, col 0.
- x=128, y=310: covers row 7, col 2. Response: `hit`=0.
- x=620, y=460: column clamps to 9 and row clamps to 10. Response: `hit`=1, row 10, col 9; 13 cycles to `done`.
- Robustness, checked on a fresh request:
  - `start` pulsed while `busy` is ignored.
  - `Reset_n` dropped mid-SCAN clears all outputs with no `done` pulse.
  - A fresh request afterwards returns correct results.

Source files
------------

// File: rtl/level_pkg.sv
// Shared constants and FSM encoding for the level tile-collision checker.
// Tile geometry matches the level_rom layout: 11 rows of 10 columns.
package level_pkg;
  localparam int ROWS        = 11;
  localparam int COLS        = 10;
  localparam int TILE_W_LOG2 = 6;
  localparam int TILE_H      = 44;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } lc_state_t;
endpackage

// File: rtl/level_collision_if.sv
// Query/response bundle between player-movement logic and the collision checker.
// The master issues start with a box position; the slave answers with busy/done/hit.
interface level_collision_if;
  logic       start;
  logic [9:0] x_px;
  logic [9:0] y_px;
  logic       busy;
  logic       done;
  logic       hit;
  logic [3:0] hit_row;
  logic [3:0] hit_col;

  modport master (
    output start, x_px, y_px,
    input  busy, done, hit, hit_row, hit_col
  );

  modport slave (
    input  start, x_px, y_px,
    output busy, done, hit, hit_row, hit_col
  );
endinterface

// File: rtl/tile_row_div.sv
// Repeated-subtraction divide by TILE_H, quotient saturating at the last row.
// One quotient step per cycle while step=1; ready once no further step applies.
module tile_row_div
  import level_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        load,
  input  logic [10:0] dividend,
  input  logic        step,
  output logic [3:0]  quotient,
  output logic        ready
);
  logic [10:0] rem;

  assign ready = (rem < 11'(TILE_H)) || (quotient == 4'(ROWS - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rem      <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= dividend;
      quotient <= '0;
    end else if (step && !ready) begin
      rem      <= rem - 11'(TILE_H);
      quotient <= quotient + 4'd1;
    end
  end
endmodule

// File: rtl/level_collision.sv
// Sprite-box vs. level tile collision check: rows r0..r1 read from level_rom one per cycle.
// Latency (r1+1) divide cycles + rows scanned + 1; start is ignored (not queued) while busy.
module level_collision
  import level_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic               Clk,
  input  logic               Reset_n,
  level_collision_if.slave   q,
  output logic [3:0]         rom_addr,
  input  logic [COLS-1:0]    rom_data
);
  lc_state_t   state;
  logic        busy_r, done_r, hit_r;
  logic [3:0]  hit_row_r, hit_col_r;
  logic [3:0]  c0, c1;
  logic [3:0]  row;

  logic        accept;
  logic [10:0] bottom_px, right_px, right_col;
  logic [3:0]  r0, r1;
  logic        rdy0, rdy1;
  logic        found;
  logic [3:0]  found_col;

  assign accept    = (state == IDLE) && q.start;
  assign bottom_px = {1'b0, q.y_px} + 11'(SPR_H - 1);
  assign right_px  = {1'b0, q.x_px} + 11'(SPR_W - 1);
  assign right_col = right_px >> TILE_W_LOG2;

  tile_row_div u_div_top (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (accept),
    .dividend ({1'b0, q.y_px}),
    .step     (state == DIV),
    .quotient (r0),
    .ready    (rdy0)
  );

  tile_row_div u_div_bot (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (accept),
    .dividend (bottom_px),
    .step     (state == DIV),
    .quotient (r1),
    .ready    (rdy1)
  );

  // Walk columns right-to-left so the leftmost solid tile in range wins.
  always_comb begin
    found     = 1'b0;
    found_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if ((4'(c) >= c0) && (4'(c) <= c1) && rom_data[COLS-1-c]) begin
        found     = 1'b1;
        found_col = 4'(c);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hit_r     <= 1'b0;
      hit_row_r <= '0;
      hit_col_r <= '0;
      c0        <= '0;
      c1        <= '0;
      row       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q.start) begin
            state     <= DIV;
            busy_r    <= 1'b1;
            c0        <= 4'(q.x_px >> TILE_W_LOG2);
            c1        <= (right_col > 11'(COLS - 1)) ? 4'(COLS - 1) : 4'(right_col);
            hit_r     <= 1'b0;
            hit_row_r <= '0;
            hit_col_r <= '0;
          end
        end
        DIV: begin
          if (rdy0 && rdy1) begin
            state <= SCAN;
            row   <= r0;
          end
        end
        SCAN: begin
          if (found) begin
            hit_r     <= 1'b1;
            hit_row_r <= row;
            hit_col_r <= found_col;
            state     <= DONE;
            done_r    <= 1'b1;
          end else if (row == r1) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            row <= row + 4'd1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rom_addr  = row;
  assign q.busy    = busy_r;
  assign q.done    = done_r;
  assign q.hit     = hit_r;
  assign q.hit_row = hit_row_r;
  assign q.hit_col = hit_col_r;
endmodule
